// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write port bundle: two pixel clients, clear control, RAM side.
// slave = arbiter side, master = client/RAM/driver side.
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              ia_valid;
  logic [ADDR_W-1:0] ia_addr;
  logic [DATA_W-1:0] ia_data;
  logic              oa_ready;
  logic              ib_valid;
  logic [ADDR_W-1:0] ib_addr;
  logic [DATA_W-1:0] ib_data;
  logic              ob_ready;
  logic              iclr_req;
  logic [DATA_W-1:0] iclr_color;
  logic              oclr_busy;
  logic              oclr_done;
  logic              ooob;
  logic              owren;
  logic [ADDR_W-1:0] oaddr;
  logic [DATA_W-1:0] odata;

  modport slave (
    input  ia_valid, ia_addr, ia_data, ib_valid, ib_addr, ib_data,
           iclr_req, iclr_color,
    output oa_ready, ob_ready, oclr_busy, oclr_done, ooob,
           owren, oaddr, odata
  );

  modport master (
    output ia_valid, ia_addr, ia_data, ib_valid, ib_addr, ib_data,
           iclr_req, iclr_color,
    input  oa_ready, ob_ready, oclr_busy, oclr_done, ooob,
           owren, oaddr, odata
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: sole owner of the frame-buffer RAM write port.
// Arbitrates two valid/ready pixel clients (round-robin) and runs a
// full-buffer clear engine that has priority over both clients.
// Optional macro FB_WRITE_ARB_FIXED_PRIO_EN: client A always beats B.
module fb_write_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int FB_WORDS = 307200
) (
  input logic               iclk,
  input logic               irst,
  fb_write_arbiter_if.slave bus
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  // one extra bit so FB_WORDS == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   FB_LIM   = (ADDR_W+1)'(FB_WORDS);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(FB_WORDS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;
  logic              gnt_a, gnt_b, pick_a, clr_last;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_inrange;
  logic              wren_q, oob_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

`ifdef FB_WRITE_ARB_FIXED_PRIO_EN
  assign pick_a = 1'b1;
`else
  logic last_grant_b;
  assign pick_a = last_grant_b;

  // remember who won last so the other client wins the next contention
  always_ff @(posedge iclk) begin
    if (irst)       last_grant_b <= 1'b1;
    else if (gnt_a) last_grant_b <= 1'b0;
    else if (gnt_b) last_grant_b <= 1'b1;
  end
`endif

  // state register
  always_ff @(posedge iclk) begin
    if (irst) state <= ARB;
    else      state <= state_nx;
  end

  // next state and grants; a clear request blocks both clients that cycle
  always_comb begin
    state_nx = state;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    clr_last = 1'b0;
    case (state)
      ARB: begin
        if (bus.iclr_req) begin
          state_nx = CLEAR;
        end else begin
          gnt_a = bus.ia_valid && (!bus.ib_valid || pick_a);
          gnt_b = bus.ib_valid && !gnt_a;
        end
      end
      CLEAR: begin
        // a restart request supersedes finishing the current pass
        clr_last = (clr_cnt == CNT_LAST) && !bus.iclr_req;
        if (clr_last) state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  assign win_addr    = gnt_a ? bus.ia_addr : bus.ib_addr;
  assign win_data    = gnt_a ? bus.ia_data : bus.ib_data;
  assign win_inrange = {1'b0, win_addr} < FB_LIM;

  // registered RAM write port, clear counter and status pulses
  always_ff @(posedge iclk) begin
    if (irst) begin
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      oob_q     <= 1'b0;
      done_q    <= 1'b0;
      clr_cnt   <= '0;
      clr_color <= '0;
    end else begin
      wren_q <= 1'b0;
      oob_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.iclr_req) begin
        clr_cnt   <= '0;
        clr_color <= bus.iclr_color;
      end else if (state == CLEAR) begin
        wren_q  <= 1'b1;
        addr_q  <= clr_cnt;
        data_q  <= clr_color;
        done_q  <= clr_last;
        clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      end else if (gnt_a || gnt_b) begin
        // out-of-range writes are swallowed and flagged instead
        if (win_inrange) begin
          wren_q <= 1'b1;
          addr_q <= win_addr;
          data_q <= win_data;
        end else begin
          oob_q <= 1'b1;
        end
      end
    end
  end

  assign bus.oa_ready  = gnt_a;
  assign bus.ob_ready  = gnt_b;
  assign bus.oclr_busy = (state == CLEAR);
  assign bus.oclr_done = done_q;
  assign bus.ooob      = oob_q;
  assign bus.owren     = wren_q;
  assign bus.oaddr     = addr_q;
  assign bus.odata     = data_q;

endmodule
